tvp5147_init_sequencer: RTL
===========================

TVP5147_INIT_SEQUENCER -- requirements
Module: tvp5147_init_sequencer

Interface
REQ-001 SHALL have parameter SLAVE_ADDR, default 8'hB8, the 8-bit I2C device address driven to the I2C master.
REQ-002 SHALL have parameter NUM_REGS, default 4, the number of table entries sent (range 1..8).
REQ-003 SHALL have parameter PWR_DELAY, default 1000, the number of idle cycles between go and the first transfer.
REQ-004 SHALL have parameter TIMEOUT, default 4096, the maximum wait in cycles for each I2C busy edge.
REQ-005 SHALL have port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-007 SHALL have port go, input, 1 bit, a pulse that starts the sequence; it is ignored unless the FSM is in IDLE, DONE or ERROR.
REQ-008 SHALL have port i2c_busy, input, 1 bit, the busy signal from the I2C master.
REQ-009 SHALL have port i2c_data_out, input, 8 bits, the read data from the I2C master.
REQ-010 SHALL have port i2c_start, output, 1 bit, a one-cycle transfer request.
REQ-011 SHALL have port i2c_rw, output, 1 bit (0 = write, 1 = read).
REQ-012 SHALL have ports i2c_slave_addr, i2c_sub_addr and i2c_data_in, outputs, 8 bits each, the transfer fields.
REQ-013 SHALL have port cfg_busy, output, 1 bit, high in every state except IDLE, DONE and ERROR.
REQ-014 SHALL have port init_done, output, 1 bit, a level that is high in DONE.
REQ-015 SHALL have port init_error, output, 1 bit, a level that is high in ERROR.
REQ-016 SHALL have port cur_index, output, 3 bits, the table entry currently in progress.

Function
REQ-017 SHALL hold a fixed internal table of {sub_addr, data} pairs:
- idx0 {8'h03, 8'h69}
- idx1 {8'h0D, 8'h47}
- idx2 {8'h00, 8'h00}
- idx3 {8'h02, 8'h00}
- idx4..7 {8'h00, 8'h00}
REQ-018 SHALL implement states IDLE, PWR_WAIT, ISSUE, WAIT_BUSY_HI, WAIT_BUSY_LO, NEXT, DONE and ERROR.
REQ-019 On go in IDLE, DONE or ERROR, the FSM SHALL go to PWR_WAIT, clear cur_index, clear init_done and init_error, and clear the delay counter.
REQ-020 PWR_WAIT SHALL last exactly PWR_DELAY cycles, then go to ISSUE.
REQ-021 ISSUE SHALL wait until i2c_busy=0, then assert i2c_start for exactly one cycle with the fields valid in that same cycle, then go to WAIT_BUSY_HI.
REQ-022 i2c_slave_addr, i2c_sub_addr, i2c_data_in and i2c_rw SHALL be registered and held stable from the ISSUE cycle until the transfer completes.
REQ-023 WAIT_BUSY_HI SHALL go to WAIT_BUSY_LO when i2c_busy=1 and to ERROR if TIMEOUT cycles elapse; the counter SHALL clear on each state entry.
REQ-024 WAIT_BUSY_LO SHALL go to NEXT when i2c_busy=0 and to ERROR after TIMEOUT cycles.
REQ-025 In NEXT, the FSM SHALL go to DONE if cur_index==NUM_REGS-1; otherwise it SHALL increment cur_index and go to ISSUE.
REQ-026 cur_index SHALL never wrap; it SHALL hold its last value in DONE and ERROR.
REQ-027 An i2c_busy=1 already present in the ISSUE cycle SHALL NOT count as the busy-high edge; detection SHALL start the cycle after i2c_start.
REQ-028 A go pulse in any other state SHALL be ignored.
REQ-029 All outputs SHALL be registered; i2c_start SHALL never be high for two consecutive cycles.

Reset
REQ-030 While rst=1 at a clock edge, the FSM SHALL enter IDLE.
REQ-031 Reset values: i2c_start=0, i2c_rw=0, i2c_slave_addr=SLAVE_ADDR, i2c_sub_addr=0, i2c_data_in=0, cfg_busy=0, init_done=0, init_error=0, cur_index=0, all counters 0.
REQ-032 A reset during any state, including mid-transfer, SHALL abort the sequence; no retry SHALL occur until the next go.

Configuration
REQ-033 With TVP_INIT_READBACK_EN defined, each write SHALL be followed by a read of the same sub_addr (i2c_rw=1) using the same ISSUE/WAIT handshake.
REQ-034 With TVP_INIT_READBACK_EN defined, the sequencer SHALL compare i2c_data_out against the table data one cycle after busy falls.
REQ-035 With TVP_INIT_READBACK_EN defined, a mismatch SHALL retry the write+read up to 2 more times, then go to ERROR; a match SHALL go to NEXT.
REQ-036 Without TVP_INIT_READBACK_EN, only writes SHALL be issued, and i2c_rw SHALL be constant 0.

Verification
REQ-037 Nominal: rst 2 cycles, go, I2C model busy=1 for 20 cycles after each start -> 4 start pulses with sub 03/0D/00/02 and data 69/47/00/00, first start at PWR_DELAY+1..+2 cycles after go, then init_done=1 and cfg_busy=0.
REQ-038 Timeout: model never raises busy -> init_error=1 exactly TIMEOUT cycles after the first start, cur_index=0, no further starts.
REQ-039 Busy already high at ISSUE: model holds busy=1 for 50 cycles before the first start -> start is delayed until busy=0, then the sequence completes normally.
REQ-040 Reset mid-transfer: rst asserted during idx2 WAIT_BUSY_LO -> next cycle all outputs at reset values; a new go restarts from idx0.
REQ-041 Go while busy: second go pulse during idx1 -> ignored, exactly 4 starts in total.
REQ-042 Readback (macro defined): model returns 8'h68 for sub 03 on every read -> 3 write+read pairs, then init_error=1 with cur_index=0.

Source files
------------

// File: rtl/tvp5147_init_sequencer.sv
// tvp5147_init_sequencer: power-up delay, then streams the register table to an I2C master.
// Define TVP_INIT_READBACK_EN to read back each register after writing it, with up to 2 retries.
module tvp5147_init_sequencer #(
    parameter logic [7:0] SLAVE_ADDR = 8'hB8,
    parameter int NUM_REGS = 4,
    parameter int PWR_DELAY = 1000,
    parameter int TIMEOUT = 4096
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       go,
    input  logic       i2c_busy,
    input  logic [7:0] i2c_data_out,
    output logic       i2c_start,
    output logic       i2c_rw,
    output logic [7:0] i2c_slave_addr,
    output logic [7:0] i2c_sub_addr,
    output logic [7:0] i2c_data_in,
    output logic       cfg_busy,
    output logic       init_done,
    output logic       init_error,
    output logic [2:0] cur_index
);
    localparam logic [15:0] TABLE [8] = '{16'h0369, 16'h0D47, 16'h0000, 16'h0200,
                                          16'h0000, 16'h0000, 16'h0000, 16'h0000};

    typedef enum logic [3:0] {IDLE, PWR_WAIT, ISSUE, WAIT_BUSY_HI, WAIT_BUSY_LO, CHECK, NEXT, DONE, ERROR} state_t;

    state_t      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [1:0]  retry_q, retry_d;
    logic        start_q, start_d, rw_q, rw_d;
    logic        busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic [7:0]  sub_q, sub_d, data_q, data_d;
    logic [15:0] entry;
    logic        timed_out;

    assign entry = TABLE[idx_q];
    assign timed_out = cnt_q == 32'(TIMEOUT - 1);

`ifndef TVP_INIT_READBACK_EN
    logic unused_data;
    assign unused_data = ^i2c_data_out;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d = '0;
        idx_d = idx_q;
        retry_d = retry_q;
        start_d = 1'b0;
        rw_d = rw_q;
        sub_d = sub_q;
        data_d = data_q;
        case (state_q)
            IDLE, DONE, ERROR: if (go) begin
                state_d = PWR_WAIT;
                idx_d = '0;
                retry_d = '0;
                rw_d = 1'b0;
            end
            PWR_WAIT: begin
                cnt_d = cnt_q + 32'd1;
                if (cnt_q == 32'(PWR_DELAY - 1)) begin
                    state_d = ISSUE;
                    cnt_d = '0;
                end
            end
            ISSUE: if (!i2c_busy) begin
                start_d = 1'b1;
                sub_d = entry[15:8];
                data_d = entry[7:0];
                state_d = WAIT_BUSY_HI;
            end
            // busy seen while start is still out predates this transfer
            WAIT_BUSY_HI: begin
                cnt_d = cnt_q + 32'd1;
                if (i2c_busy && !start_q) begin
                    state_d = WAIT_BUSY_LO;
                    cnt_d = '0;
                end else if (timed_out) state_d = ERROR;
            end
            WAIT_BUSY_LO: begin
                cnt_d = cnt_q + 32'd1;
                if (!i2c_busy) begin
                    cnt_d = '0;
`ifdef TVP_INIT_READBACK_EN
                    state_d = rw_q ? CHECK : ISSUE;
                    rw_d = !rw_q;
`else
                    state_d = NEXT;
`endif
                end else if (timed_out) state_d = ERROR;
            end
`ifdef TVP_INIT_READBACK_EN
            CHECK: if (i2c_data_out == data_q) state_d = NEXT;
                   else if (retry_q == 2'd2) state_d = ERROR;
                   else begin
                       retry_d = retry_q + 2'd1;
                       state_d = ISSUE;
                   end
`endif
            NEXT: begin
                retry_d = '0;
                if (idx_q == 3'(NUM_REGS - 1)) state_d = DONE;
                else begin
                    idx_d = idx_q + 3'd1;
                    state_d = ISSUE;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = !(state_d == IDLE || state_d == DONE || state_d == ERROR);
        done_d = state_d == DONE;
        err_d = state_d == ERROR;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q <= '0;
            idx_q <= '0;
            retry_q <= '0;
            start_q <= 1'b0;
            rw_q <= 1'b0;
            sub_q <= '0;
            data_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            retry_q <= retry_d;
            start_q <= start_d;
            rw_q <= rw_d;
            sub_q <= sub_d;
            data_q <= data_d;
            busy_q <= busy_d;
            done_q <= done_d;
            err_q <= err_d;
        end
    end

    assign i2c_start = start_q;
    assign i2c_rw = rw_q;
    assign i2c_slave_addr = SLAVE_ADDR;
    assign i2c_sub_addr = sub_q;
    assign i2c_data_in = data_q;
    assign cfg_busy = busy_q;
    assign init_done = done_q;
    assign init_error = err_q;
    assign cur_index = idx_q;
endmodule
